// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage.
//   - mem_state_e     : access FSM states
//   - Lm*             : bit positions inside the one-hot load-type mask
//   - be_popcount     : number of enabled store byte lanes
//   - store_replicate : lane replication of store data chosen by store width
//   - is_misaligned   : natural-alignment check used by the optional
//                       misaligned-access exception (MEM_MISALIGN_EXP_EN)
package mem_stage_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StRdata = 2'd2
  } mem_state_e;

  // One-hot load-type mask bit positions
  localparam int unsigned LmLb  = 0;
  localparam int unsigned LmLh  = 1;
  localparam int unsigned LmLw  = 2;
  localparam int unsigned LmLbu = 3;
  localparam int unsigned LmLhu = 4;

  // Loads always fetch the whole word; the lane is picked on return
  localparam logic [3:0] BeWord = 4'b1111;

  function automatic logic [2:0] be_popcount(input logic [3:0] be);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, be[i]};
    end
    return n;
  endfunction

  // Store width follows the number of enabled lanes, so the data is copied
  // into every lane and the byte enables pick the one(s) that land.
  function automatic logic [31:0] store_replicate(input logic [31:0] rs2,
                                                  input logic [3:0]  be);
    logic [31:0] res;
    unique case (be_popcount(be))
      3'd1:    res = {4{rs2[7:0]}};
      3'd2:    res = {2{rs2[15:0]}};
      default: res = rs2;
    endcase
    return res;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                         input logic [4:0] l_mask,
                                         input logic [3:0] be,
                                         input logic       is_store);
    logic half, word;
    half = is_store ? (be_popcount(be) == 3'd2) : (l_mask[LmLh] | l_mask[LmLhu]);
    word = is_store ? (be_popcount(be) == 3'd4) : l_mask[LmLw];
    return (half & addr_lo[0]) | (word & (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment and extension (purely combinational).
// Ports:
//   rdata   - raw word returned by the data memory
//   addr_lo - low two bits of the load byte address
//   l_mask  - one-hot load type (LB, LH, LW, LBU, LHU)
//   ldata   - lane-selected, sign- or zero-extended result
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [4:0]  l_mask,
  output logic [31:0] ldata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    unique case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    ldata = rdata;
    unique case (1'b1)
      l_mask[LmLb]:  ldata = {{24{lane_b[7]}}, lane_b};
      l_mask[LmLh]:  ldata = {{16{lane_h[15]}}, lane_h};
      l_mask[LmLw]:  ldata = rdata;
      l_mask[LmLbu]: ldata = {24'h0, lane_b};
      l_mask[LmLhu]: ldata = {16'h0, lane_h};
      default:       ldata = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage.
// Takes load/store control from the execute stage, runs a req/gnt/rvalid
// handshake with the data memory, stalls upstream until the access is done and
// produces registered writeback outputs (wb_data doubles as forwarding data).
// Optional feature macro: MEM_MISALIGN_EXP_EN -- when defined, naturally
// misaligned half/word accesses raise mem_exp_flag instead of touching the bus.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   ex_*                         - execute-stage instruction and operands
//   mem_flush                    - kill from commit logic
//   mem_stall                    - hold all upstream stages
//   dmem_req/we/addr/be/wdata    - data memory request
//   dmem_gnt/rvalid/rdata        - data memory response
//   wb_valid/req_rf/rf_waddr/data- writeback entry
//   mem_exp_flag                 - misaligned-access exception
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned RF_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_valid,
  input  logic                     ex_req_rf,
  input  logic [RF_ADDR_WIDTH-1:0] ex_rf_waddr,
  input  logic [XLEN-1:0]          ex_alu_res,
  input  logic                     ex_mem_re,
  input  logic                     ex_mem_we,
  input  logic [XLEN-1:0]          ex_ls_addr,
  input  logic [4:0]               ex_l_mask,
  input  logic [3:0]               ex_byte_we,
  input  logic [XLEN-1:0]          ex_rs2,
  input  logic                     mem_flush,
  output logic                     mem_stall,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [XLEN-1:0]          dmem_addr,
  output logic [3:0]               dmem_be,
  output logic [XLEN-1:0]          dmem_wdata,
  input  logic                     dmem_gnt,
  input  logic                     dmem_rvalid,
  input  logic [XLEN-1:0]          dmem_rdata,
  output logic                     wb_valid,
  output logic                     wb_req_rf,
  output logic [RF_ADDR_WIDTH-1:0] wb_rf_waddr,
  output logic [XLEN-1:0]          wb_data,
  output logic                     mem_exp_flag
);

  mem_state_e state_q, state_d;

  // Transaction context latched when an access leaves IDLE
  logic [XLEN-1:0]          addr_q, addr_d;
  logic [1:0]               addr_lo_q, addr_lo_d;
  logic [3:0]               be_q, be_d;
  logic [XLEN-1:0]          wdata_q, wdata_d;
  logic                     we_q, we_d;
  logic [4:0]               l_mask_q, l_mask_d;
  logic                     req_rf_q, req_rf_d;
  logic [RF_ADDR_WIDTH-1:0] rd_q, rd_d;
  // Set once a flush hits an in-flight access; the completion is then dropped
  logic                     kill_q, kill_d;

  logic                     wb_valid_q, wb_valid_d;
  logic                     wb_req_rf_q, wb_req_rf_d;
  logic [RF_ADDR_WIDTH-1:0] wb_rf_waddr_q, wb_rf_waddr_d;
  logic [XLEN-1:0]          wb_data_q, wb_data_d;

  logic                     access;
  logic                     discard;
  logic [XLEN-1:0]          load_data;

`ifdef MEM_MISALIGN_EXP_EN
  logic                     exp_q, exp_d;
  logic                     misalign;

  assign misalign = is_misaligned(ex_ls_addr[1:0], ex_l_mask, ex_byte_we, ex_mem_we);
`endif

  assign access  = ex_valid & (ex_mem_re | ex_mem_we);
  assign discard = kill_q | mem_flush;

  mem_load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (addr_lo_q),
    .l_mask  (l_mask_q),
    .ldata   (load_data)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    addr_lo_d     = addr_lo_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    we_d          = we_q;
    l_mask_d      = l_mask_q;
    req_rf_d      = req_rf_q;
    rd_d          = rd_q;
    kill_d        = kill_q;
    wb_valid_d    = 1'b0;
    wb_req_rf_d   = 1'b0;
    wb_rf_waddr_d = wb_rf_waddr_q;
    wb_data_d     = wb_data_q;
    mem_stall     = 1'b0;
`ifdef MEM_MISALIGN_EXP_EN
    exp_d         = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        kill_d = 1'b0;
`ifdef MEM_MISALIGN_EXP_EN
        if (access && !mem_flush && misalign) begin
          // Faulting access retires at once carrying its address
          wb_valid_d    = 1'b1;
          wb_rf_waddr_d = ex_rf_waddr;
          wb_data_d     = ex_ls_addr;
          exp_d         = 1'b1;
        end else
`endif
        if (access && !mem_flush) begin
          mem_stall = 1'b1;
          state_d   = StReq;
          addr_d    = {ex_ls_addr[XLEN-1:2], 2'b00};
          addr_lo_d = ex_ls_addr[1:0];
          be_d      = ex_mem_we ? ex_byte_we : BeWord;
          wdata_d   = ex_mem_we ? store_replicate(ex_rs2, ex_byte_we) : '0;
          we_d      = ex_mem_we;
          l_mask_d  = ex_l_mask;
          req_rf_d  = ex_req_rf;
          rd_d      = ex_rf_waddr;
        end else begin
          // Non-memory op (or a flushed access): one-cycle pass-through
          wb_valid_d    = ex_valid & ~mem_flush;
          wb_req_rf_d   = ex_req_rf & ex_valid & ~mem_flush;
          wb_rf_waddr_d = ex_rf_waddr;
          wb_data_d     = ex_alu_res;
        end
      end

      StReq: begin
        mem_stall = 1'b1;
        if (mem_flush) begin
          kill_d = 1'b1;
        end
        // rvalid is ignored here; the bus never returns data with the grant
        if (dmem_gnt) begin
          if (we_q) begin
            mem_stall     = 1'b0;
            state_d       = StIdle;
            wb_valid_d    = ~discard;
            wb_rf_waddr_d = rd_q;
          end else begin
            state_d = StRdata;
          end
        end else if (mem_flush) begin
          state_d = StIdle;
        end
      end

      StRdata: begin
        mem_stall = ~dmem_rvalid;
        if (mem_flush) begin
          kill_d = 1'b1;
        end
        if (dmem_rvalid) begin
          state_d       = StIdle;
          wb_valid_d    = ~discard;
          wb_req_rf_d   = req_rf_q & ~discard;
          wb_rf_waddr_d = rd_q;
          wb_data_d     = load_data;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      addr_lo_q     <= '0;
      be_q          <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      l_mask_q      <= '0;
      req_rf_q      <= 1'b0;
      rd_q          <= '0;
      kill_q        <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_req_rf_q   <= 1'b0;
      wb_rf_waddr_q <= '0;
      wb_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      addr_lo_q     <= addr_lo_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      we_q          <= we_d;
      l_mask_q      <= l_mask_d;
      req_rf_q      <= req_rf_d;
      rd_q          <= rd_d;
      kill_q        <= kill_d;
      wb_valid_q    <= wb_valid_d;
      wb_req_rf_q   <= wb_req_rf_d;
      wb_rf_waddr_q <= wb_rf_waddr_d;
      wb_data_q     <= wb_data_d;
    end
  end

`ifdef MEM_MISALIGN_EXP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
    end
  end

  assign mem_exp_flag = exp_q;
`else
  assign mem_exp_flag = 1'b0;
`endif

  assign dmem_req    = (state_q == StReq);
  assign dmem_we     = dmem_req & we_q;
  assign dmem_addr   = addr_q;
  assign dmem_be     = be_q;
  assign dmem_wdata  = wdata_q;

  assign wb_valid    = wb_valid_q;
  assign wb_req_rf   = wb_req_rf_q;
  assign wb_rf_waddr = wb_rf_waddr_q;
  assign wb_data     = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// back-to-back traffic checked against a behavioural reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_req_rf, ex_mem_re, ex_mem_we, mem_flush;
  logic [4:0]  ex_rf_waddr, ex_l_mask;
  logic [31:0] ex_alu_res, ex_ls_addr, ex_rs2;
  logic [3:0]  ex_byte_we;
  logic        mem_stall, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_req_rf, mem_exp_flag;
  logic [4:0]  wb_rf_waddr;
  logic [31:0] wb_data;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [4:0] LB = 5'b00001, LH = 5'b00010, LW = 5'b00100;
  localparam logic [4:0] LBU = 5'b01000, LHU = 5'b10000;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_req_rf   (ex_req_rf),
    .ex_rf_waddr (ex_rf_waddr),
    .ex_alu_res  (ex_alu_res),
    .ex_mem_re   (ex_mem_re),
    .ex_mem_we   (ex_mem_we),
    .ex_ls_addr  (ex_ls_addr),
    .ex_l_mask   (ex_l_mask),
    .ex_byte_we  (ex_byte_we),
    .ex_rs2      (ex_rs2),
    .mem_flush   (mem_flush),
    .mem_stall   (mem_stall),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .wb_valid    (wb_valid),
    .wb_req_rf   (wb_req_rf),
    .wb_rf_waddr (wb_rf_waddr),
    .wb_data     (wb_data),
    .mem_exp_flag(mem_exp_flag)
  );

  // Reference model: load result from the raw word, address and load kind
  // (kind 0..4 = LB, LH, LW, LBU, LHU)
  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                           input int kind);
    int unsigned w, b, h;
    w = rdata;
    b = (w >> (8 * (addr % 4))) % 256;
    h = (w >> (16 * ((addr / 2) % 2))) % 65536;
    case (kind)
      0:       return (b >= 128) ? b - 256 : b;
      1:       return (h >= 32768) ? h - 65536 : h;
      3:       return b;
      4:       return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] rs2, input logic [3:0] be);
    int unsigned v;
    v = rs2;
    if ($countones(be) == 1) return (v % 256) * 32'h0101_0101;
    if ($countones(be) == 2) return (v % 65536) * 32'h0001_0001;
    return rs2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_req_rf = 0; ex_mem_re = 0; ex_mem_we = 0; mem_flush = 0;
    ex_rf_waddr = 0; ex_l_mask = 0; ex_alu_res = 0; ex_ls_addr = 0; ex_rs2 = 0;
    ex_byte_we = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  // Drives one non-memory op and returns what the DUT showed (no checking here)
  task automatic run_alu(input logic [31:0] res, input logic [4:0] rd, input bit rf,
                         input bit vld, input bit fl, output bit stall,
                         output bit wbv, output bit wbr, output logic [4:0] wba,
                         output logic [31:0] wbd);
    ex_valid = vld; ex_mem_re = 0; ex_mem_we = 0; ex_alu_res = res; ex_rf_waddr = rd;
    ex_req_rf = rf; mem_flush = fl;
    #1 stall = mem_stall;
    step();
    wbv = wb_valid; wbr = wb_req_rf; wba = wb_rf_waddr; wbd = wb_data;
    ex_valid = 0; mem_flush = 0;
  endtask

  // Drives one load/store with the given grant/rvalid latencies and records
  // what the DUT showed (no checking here)
  task automatic run_mem(input bit st, input logic [4:0] lm, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdata, input logic [4:0] rd, input bit rf,
                         input int gnt_dly, input int rv_dly,
                         output int stall_cnt, output int req_cnt, output bit done_stall,
                         output logic [31:0] o_addr, output logic [3:0] o_be,
                         output logic [31:0] o_wdata, output bit o_we,
                         output bit wbv, output bit wbr, output logic [4:0] wba,
                         output logic [31:0] wbd);
    stall_cnt = 0; req_cnt = 0;
    ex_valid = 1; ex_mem_re = !st; ex_mem_we = st; ex_l_mask = st ? 5'b0 : lm;
    ex_byte_we = st ? be : 4'b0; ex_ls_addr = addr; ex_rs2 = rs2; ex_rf_waddr = rd;
    ex_req_rf = rf; ex_alu_res = $urandom;
    #1 if (mem_stall) stall_cnt++;
    step();
    o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata; o_we = dmem_we;
    for (int i = 0; i < gnt_dly; i++) begin
      if (mem_stall) stall_cnt++;
      if (dmem_req) req_cnt++;
      step();
    end
    dmem_gnt = 1;
    #1 if (mem_stall) stall_cnt++;
    if (dmem_req) req_cnt++;
    done_stall = mem_stall;
    step();
    dmem_gnt = 0;
    if (!st) begin
      for (int i = 0; i < rv_dly; i++) begin
        if (mem_stall) stall_cnt++;
        step();
      end
      dmem_rvalid = 1; dmem_rdata = rdata;
      #1 done_stall = mem_stall;
      step();
      dmem_rvalid = 0; dmem_rdata = $urandom;
    end
    wbv = wb_valid; wbr = wb_req_rf; wba = wb_rf_waddr; wbd = wb_data;
    ex_valid = 0; ex_mem_re = 0; ex_mem_we = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step(); step();
    rst = 0;
    #1;
    n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset wb_valid got %b want 0", wb_valid); end
    n_vec++; if (wb_req_rf !== 1'b0) begin n_err++; $display("FAIL reset wb_req_rf got %b want 0", wb_req_rf); end
    n_vec++; if (wb_rf_waddr !== 5'd0) begin n_err++; $display("FAIL reset wb_rf_waddr got %h want 0", wb_rf_waddr); end
    n_vec++; if (wb_data !== 32'd0) begin n_err++; $display("FAIL reset wb_data got %h want 0", wb_data); end
    n_vec++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin n_err++; $display("FAIL reset req/we got %b%b want 00", dmem_req, dmem_we); end
    n_vec++; if (dmem_addr !== 32'd0 || dmem_be !== 4'd0 || dmem_wdata !== 32'd0) begin
      n_err++; $display("FAIL reset bus fields got %h/%h/%h want 0", dmem_addr, dmem_be, dmem_wdata); end
    n_vec++; if (mem_exp_flag !== 1'b0) begin n_err++; $display("FAIL reset exp got %b want 0", mem_exp_flag); end
    n_vec++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL reset stall got %b want 0", mem_stall); end
  endtask

  task automatic test_reset_mid();
    ex_valid = 1; ex_mem_re = 1; ex_l_mask = LW; ex_ls_addr = 32'h500; ex_req_rf = 1;
    step();
    n_vec++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL rstmid req_before got %b want 1", dmem_req); end
    rst = 1;
    step();
    rst = 0; ex_valid = 0; ex_mem_re = 0;
    #1;
    n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL rstmid req_after got %b want 0", dmem_req); end
    n_vec++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL rstmid stall got %b want 0", mem_stall); end
    step();
    n_vec++; if (dmem_req !== 1'b0 || wb_valid !== 1'b0) begin
      n_err++; $display("FAIL rstmid idle got req=%b wbv=%b want 0/0", dmem_req, wb_valid); end
  endtask

  task automatic test_alu();
    bit st, v, r; logic [4:0] a; logic [31:0] d, res; logic [4:0] rd;
    run_alu(32'h1234_5678, 5'd5, 1, 1, 0, st, v, r, a, d);
    n_vec++; if (st !== 1'b0) begin n_err++; $display("FAIL alu stall got %b want 0", st); end
    n_vec++; if ({v, r} !== 2'b11) begin n_err++; $display("FAIL alu valid/req got %b%b want 11", v, r); end
    n_vec++; if (a !== 5'd5 || d !== 32'h1234_5678) begin n_err++; $display("FAIL alu rd/data got %0d/%h want 5/12345678", a, d); end
    for (int i = 0; i < 6; i++) begin
      res = $urandom; rd = 5'($urandom);
      run_alu(res, rd, i[0], 1, 0, st, v, r, a, d);
      n_vec++; if (st !== 0 || v !== 1 || r !== i[0] || a !== rd || d !== res) begin
        n_err++; $display("FAIL alu_rand got st=%b v=%b r=%b a=%0d d=%h want 0/1/%b/%0d/%h", st, v, r, a, d, i[0], rd, res); end
    end
    run_alu(32'hABCD, 5'd3, 1, 1, 1, st, v, r, a, d);
    n_vec++; if ({v, r} !== 2'b00) begin n_err++; $display("FAIL alu_flush valid/req got %b%b want 00", v, r); end
    run_alu(32'hABCD, 5'd3, 1, 0, 0, st, v, r, a, d);
    n_vec++; if ({v, r} !== 2'b00) begin n_err++; $display("FAIL alu_novalid valid/req got %b%b want 00", v, r); end
  endtask

  task automatic test_load();
    int sc, rc; bit ds, we, v, r; logic [31:0] oa, ow, d; logic [3:0] ob; logic [4:0] a;
    run_mem(0, LW, 4'b0, 32'h100, 0, 32'hDEAD_BEEF, 5'd9, 1, 2, 0, sc, rc, ds, oa, ob, ow, we, v, r, a, d);
    n_vec++; if (sc !== 4 || ds !== 1'b0) begin n_err++; $display("FAIL lw stall cycles got %0d/%b want 4/0", sc, ds); end
    n_vec++; if (rc !== 3 || oa !== 32'h100 || ob !== 4'hF || we !== 1'b0) begin
      n_err++; $display("FAIL lw bus got req=%0d a=%h be=%h we=%b want 3/100/f/0", rc, oa, ob, we); end
    n_vec++; if (v !== 1 || r !== 1 || a !== 5'd9 || d !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL lw wb got %b%b %0d %h want 11 9 deadbeef", v, r, a, d); end
    run_mem(0, LB, 4'b0, 32'h103, 0, 32'h80FF_0000, 5'd1, 1, 0, 1, sc, rc, ds, oa, ob, ow, we, v, r, a, d);
    n_vec++; if (d !== 32'hFFFF_FF80 || oa !== 32'h100) begin n_err++; $display("FAIL lb data got %h @%h want ffffff80 @100", d, oa); end
    run_mem(0, LHU, 4'b0, 32'h102, 0, 32'hBEEF_1234, 5'd2, 1, 1, 0, sc, rc, ds, oa, ob, ow, we, v, r, a, d);
    n_vec++; if (d !== 32'h0000_BEEF) begin n_err++; $display("FAIL lhu data got %h want 0000beef", d); end
    run_mem(0, LH, 4'b0, 32'h102, 0, 32'hBEEF_1234, 5'd2, 0, 0, 0, sc, rc, ds, oa, ob, ow, we, v, r, a, d);
    n_vec++; if (d !== 32'hFFFF_BEEF || r !== 1'b0 || v !== 1'b1) begin
      n_err++; $display("FAIL lh data got %h v=%b r=%b want ffffbeef 1 0", d, v, r); end
  endtask

  task automatic test_store();
    int sc, rc; bit ds, we, v, r; logic [31:0] oa, ow, d; logic [3:0] ob; logic [4:0] a;
    run_mem(1, 5'b0, 4'b0010, 32'h201, 32'h0000_00A5, 0, 5'd4, 1, 1, 0, sc, rc, ds, oa, ob, ow, we, v, r, a, d);
    n_vec++; if (oa !== 32'h200 || ob !== 4'b0010 || ow !== 32'hA5A5_A5A5 || we !== 1'b1) begin
      n_err++; $display("FAIL sb bus got a=%h be=%b wd=%h we=%b want 200/0010/a5a5a5a5/1", oa, ob, ow, we); end
    n_vec++; if (v !== 1'b1 || r !== 1'b0) begin n_err++; $display("FAIL sb wb got v=%b r=%b want 1/0", v, r); end
    n_vec++; if (sc !== 2 || ds !== 1'b0 || rc !== 2) begin n_err++; $display("FAIL sb stall got %0d/%b req=%0d want 2/0/2", sc, ds, rc); end
    run_mem(1, 5'b0, 4'b1100, 32'h20E, 32'h1234_CAFE, 0, 5'd4, 1, 0, 0, sc, rc, ds, oa, ob, ow, we, v, r, a, d);
    n_vec++; if (oa !== 32'h20C || ob !== 4'b1100 || ow !== 32'hCAFE_CAFE) begin
      n_err++; $display("FAIL sh bus got a=%h be=%b wd=%h want 20c/1100/cafecafe", oa, ob, ow); end
  endtask

  task automatic test_flush();
    // flush in IDLE: no request at all
    ex_valid = 1; ex_mem_re = 1; ex_l_mask = LW; ex_ls_addr = 32'h600; mem_flush = 1;
    #1;
    n_vec++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL flush_idle stall got %b want 0", mem_stall); end
    step();
    ex_valid = 0; ex_mem_re = 0; mem_flush = 0;
    n_vec++; if (dmem_req !== 1'b0 || wb_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_idle got req=%b wbv=%b want 0/0", dmem_req, wb_valid); end
    // flush in REQ before grant
    ex_valid = 1; ex_mem_re = 1; ex_req_rf = 1;
    step();
    mem_flush = 1;
    step();
    mem_flush = 0; ex_valid = 0; ex_mem_re = 0;
    n_vec++; if (dmem_req !== 1'b0 || wb_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_req got req=%b wbv=%b want 0/0", dmem_req, wb_valid); end
    step();
    n_vec++; if (dmem_req !== 1'b0 || wb_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_req_after got req=%b wbv=%b want 0/0", dmem_req, wb_valid); end
    // flush in RDATA: wait for rvalid, then discard
    ex_valid = 1; ex_mem_re = 1; ex_rf_waddr = 7;
    step();
    dmem_gnt = 1;
    step();
    dmem_gnt = 0; mem_flush = 1;
    step();
    mem_flush = 0; ex_valid = 0; ex_mem_re = 0;
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (mem_stall !== 1'b1 || wb_valid !== 1'b0) begin
        n_err++; $display("FAIL flush_rdata wait%0d got stall=%b wbv=%b want 1/0", i, mem_stall, wb_valid); end
      step();
    end
    dmem_rvalid = 1; dmem_rdata = 32'h1111_2222;
    #1;
    n_vec++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL flush_rdata done stall got %b want 0", mem_stall); end
    step();
    dmem_rvalid = 0;
    n_vec++; if (wb_valid !== 1'b0 || wb_req_rf !== 1'b0) begin
      n_err++; $display("FAIL flush_rdata wb got %b%b want 00", wb_valid, wb_req_rf); end
    // flush together with a store grant: completes, result dropped
    ex_valid = 1; ex_mem_we = 1; ex_byte_we = 4'hF; ex_ls_addr = 32'h700;
    step();
    dmem_gnt = 1; mem_flush = 1;
    #1;
    n_vec++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL flush_gnt stall got %b want 0", mem_stall); end
    step();
    dmem_gnt = 0; mem_flush = 0; ex_valid = 0; ex_mem_we = 0;
    n_vec++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
      n_err++; $display("FAIL flush_gnt got wbv=%b req=%b want 0/0", wb_valid, dmem_req); end
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_EXP_EN
    ex_valid = 1; ex_mem_re = 1; ex_l_mask = LW; ex_ls_addr = 32'h302; ex_req_rf = 1;
    ex_rf_waddr = 5'd6;
    #1;
    n_vec++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL misalign stall got %b want 0", mem_stall); end
    step();
    ex_valid = 0; ex_mem_re = 0;
    n_vec++; if (dmem_req !== 1'b0 || mem_exp_flag !== 1'b1) begin
      n_err++; $display("FAIL misalign req/exp got %b/%b want 0/1", dmem_req, mem_exp_flag); end
    n_vec++; if (wb_valid !== 1'b1 || wb_req_rf !== 1'b0 || wb_data !== 32'h302) begin
      n_err++; $display("FAIL misalign wb got %b%b %h want 10 302", wb_valid, wb_req_rf, wb_data); end
    step();
    n_vec++; if (mem_exp_flag !== 1'b0 || dmem_req !== 1'b0) begin
      n_err++; $display("FAIL misalign pulse got exp=%b req=%b want 0/0", mem_exp_flag, dmem_req); end
`else
    int sc, rc; bit ds, we, v, r; logic [31:0] oa, ow, d; logic [3:0] ob; logic [4:0] a;
    run_mem(0, LW, 4'b0, 32'h302, 0, 32'h5566_7788, 5'd6, 1, 0, 0, sc, rc, ds, oa, ob, ow, we, v, r, a, d);
    n_vec++; if (oa !== 32'h300 || rc !== 1) begin n_err++; $display("FAIL noexp bus got a=%h req=%0d want 300/1", oa, rc); end
    n_vec++; if (d !== 32'h5566_7788 || v !== 1'b1 || mem_exp_flag !== 1'b0) begin
      n_err++; $display("FAIL noexp wb got %h v=%b exp=%b want 55667788 1 0", d, v, mem_exp_flag); end
`endif
  endtask

  task automatic test_back_to_back();
    int sc, rc; bit ds, we, v, r, st; logic [31:0] oa, ow, d; logic [3:0] ob; logic [4:0] a;
    logic [31:0] addr, rs2, rdata, res; logic [3:0] be; logic [4:0] rd;
    int kind, gd, rvd, esc;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 8);
      addr = $urandom; rs2 = $urandom; rdata = $urandom; res = $urandom; rd = 5'($urandom);
      gd = $urandom_range(0, 3); rvd = $urandom_range(0, 3);
      if (kind < 2) begin
        run_alu(res, rd, 1, 1, 0, st, v, r, a, d);
        n_vec++; if (st !== 0 || v !== 1 || r !== 1 || a !== rd || d !== res) begin
          n_err++; $display("FAIL b2b alu %0d got st=%b v=%b r=%b a=%0d d=%h want 0/1/1/%0d/%h", n, st, v, r, a, d, rd, res); end
      end else if (kind < 7) begin
        kind = kind - 2;
        if (kind == 2) addr = addr & ~32'd3;
        if (kind == 1 || kind == 4) addr = addr & ~32'd1;
        run_mem(0, 5'(1 << kind), 4'b0, addr, 0, rdata, rd, 1, gd, rvd, sc, rc, ds, oa, ob, ow, we, v, r, a, d);
        esc = 2 + gd + rvd;
        n_vec++; if (sc !== esc || ds !== 0 || rc !== gd + 1) begin
          n_err++; $display("FAIL b2b ld_hs %0d got stall=%0d/%b req=%0d want %0d/0/%0d", n, sc, ds, rc, esc, gd + 1); end
        n_vec++; if (oa !== (addr & ~32'd3) || ob !== 4'hF || we !== 0) begin
          n_err++; $display("FAIL b2b ld_bus %0d got a=%h be=%h we=%b want %h/f/0", n, oa, ob, we, addr & ~32'd3); end
        n_vec++; if (v !== 1 || r !== 1 || a !== rd || d !== ref_load(rdata, addr, kind)) begin
          n_err++; $display("FAIL b2b ld_wb %0d k=%0d got v=%b r=%b a=%0d d=%h want 1/1/%0d/%h", n, kind, v, r, a, d, rd, ref_load(rdata, addr, kind)); end
      end else begin
        kind = $urandom_range(0, 2);
        if (kind == 0) be = 4'(1 << (addr % 4));
        else if (kind == 1) begin addr = addr & ~32'd1; be = ((addr / 2) % 2 == 1) ? 4'b1100 : 4'b0011; end
        else begin addr = addr & ~32'd3; be = 4'b1111; end
        run_mem(1, 5'b0, be, addr, rs2, 0, rd, 1, gd, 0, sc, rc, ds, oa, ob, ow, we, v, r, a, d);
        n_vec++; if (sc !== 1 + gd || ds !== 0 || rc !== gd + 1) begin
          n_err++; $display("FAIL b2b st_hs %0d got stall=%0d/%b req=%0d want %0d/0/%0d", n, sc, ds, rc, 1 + gd, gd + 1); end
        n_vec++; if (oa !== (addr & ~32'd3) || ob !== be || we !== 1 || ow !== ref_store(rs2, be)) begin
          n_err++; $display("FAIL b2b st_bus %0d got a=%h be=%b wd=%h we=%b want %h/%b/%h/1", n, oa, ob, ow, we, addr & ~32'd3, be, ref_store(rs2, be)); end
        n_vec++; if (v !== 1 || r !== 0) begin n_err++; $display("FAIL b2b st_wb %0d got v=%b r=%b want 1/0", n, v, r); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_reset_mid();
    test_alu();
    test_load();
    test_store();
    test_flush();
    test_misalign();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
